// File: rtl/intersection_controller_if.sv
// intersection_controller_if
//   Control/status bundle between the intersection phase sequencer and
//   whatever drives it and consumes its outputs.
//   Signals:
//     run          1 = sequence normally, 0 = force all-stop
//     ped_request  pedestrian button (level or pulse), clock-synchronous
//     enable_ns    enable for the north-south traffic_light
//     enable_ew    enable for the east-west traffic_light
//     master_timer shared countdown in seconds (7 bits)
//     ped_ack      one-cycle pulse when a pending pedestrian request is served
//   Modports:
//     master  the sequencer (drives enables, timer, ack)
//     slave   the environment (drives run, ped_request)
interface intersection_controller_if;
   logic       run;
   logic       ped_request;
   logic       enable_ns;
   logic       enable_ew;
   logic [6:0] master_timer;
   logic       ped_ack;

   modport master (
      input  run,
      input  ped_request,
      output enable_ns,
      output enable_ew,
      output master_timer,
      output ped_ack
   );

   modport slave (
      output run,
      output ped_request,
      input  enable_ns,
      input  enable_ew,
      input  master_timer,
      input  ped_ack
   );
endinterface

// File: rtl/intersection_controller.sv
// intersection_controller
//   Phase sequencer for a two-way intersection. Divides the clock into
//   one-second ticks, runs the shared master_timer countdown and alternates
//   right-of-way NS_GO -> NS_CLEAR -> EW_GO -> EW_CLEAR -> NS_GO, with an
//   all-red clearance interval (timer held at 0) between phases.
//   Parameters:
//     TICKS_PER_SECOND  clock cycles per timer second (>=1)
//     PHASE_TIME        seconds loaded at the start of each GO phase (16..127)
//     ALL_RED_TIME      seconds of clearance after each GO phase (1..15)
//   Ports:
//     clock  single clock, rising edge
//     reset  asynchronous, active-high
//     bus    intersection_controller_if.master (run, ped_request in;
//            enable_ns, enable_ew, master_timer, ped_ack out; all registered)
//   Build option:
//     PED_REQUEST_EN  when defined, a pedestrian request during GO shortens
//                     the remaining green to 15 s (or is acknowledged at GO
//                     exit if already <= 15 s). When undefined, ped_request is
//                     ignored and ped_ack is tied low.
module intersection_controller #(
   parameter int unsigned TICKS_PER_SECOND = 50000000,
   parameter int unsigned PHASE_TIME       = 45,
   parameter int unsigned ALL_RED_TIME     = 3
) (
   input logic                       clock,
   input logic                       reset,
   intersection_controller_if.master bus
);

   localparam int unsigned PRE_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICKS_PER_SECOND - 1);
   localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
   localparam logic [6:0]       PHASE_LOAD = 7'(PHASE_TIME);
   localparam logic [3:0]       CLEAR_LAST = 4'(ALL_RED_TIME - 1);
   localparam logic [6:0]       PED_LOAD   = 7'd15;

   typedef enum logic [2:0] {
      STOP,
      NS_GO,
      NS_CLEAR,
      EW_GO,
      EW_CLEAR
   } state_t;

   state_t           state;
   logic [PRE_W-1:0] prescaler;
   logic [3:0]       clear_count;
   logic             armed;
   logic             tick;
   logic             ped_cut;

   assign tick = (prescaler == PRE_LAST);

`ifdef PED_REQUEST_EN
   logic latch;
   // A pending request only truncates while more than 15 s remain.
   assign ped_cut = latch && (bus.master_timer > PED_LOAD);
`else
   assign ped_cut     = 1'b0;
   assign bus.ped_ack = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= STOP;
         prescaler        <= '0;
         clear_count      <= '0;
         armed            <= 1'b0;
         bus.enable_ns    <= 1'b0;
         bus.enable_ew    <= 1'b0;
         bus.master_timer <= '0;
`ifdef PED_REQUEST_EN
         latch            <= 1'b0;
         bus.ped_ack      <= 1'b0;
`endif
      end else begin
         // STOP is held for one full cycle after reset release before the
         // first NS_GO; later run re-assertions restart immediately.
         armed <= 1'b1;
`ifdef PED_REQUEST_EN
         bus.ped_ack <= 1'b0;
`endif
         if (!bus.run) begin
            state            <= STOP;
            prescaler        <= '0;
            clear_count      <= '0;
            bus.enable_ns    <= 1'b0;
            bus.enable_ew    <= 1'b0;
            bus.master_timer <= '0;
`ifdef PED_REQUEST_EN
            latch            <= 1'b0;
`endif
         end else begin
            case (state)
               STOP: begin
                  prescaler        <= '0;
                  clear_count      <= '0;
                  bus.enable_ns    <= 1'b0;
                  bus.enable_ew    <= 1'b0;
                  bus.master_timer <= '0;
                  if (armed) begin
                     state            <= NS_GO;
                     bus.enable_ns    <= 1'b1;
                     bus.master_timer <= PHASE_LOAD;
                  end
               end

               NS_GO, EW_GO: begin
                  prescaler <= tick ? '0 : prescaler + PRE_ONE;
`ifdef PED_REQUEST_EN
                  // Set first so that a same-edge service below wins.
                  if (bus.ped_request) begin
                     latch <= 1'b1;
                  end
`endif
                  if (tick) begin
                     if (ped_cut) begin
                        bus.master_timer <= PED_LOAD;
`ifdef PED_REQUEST_EN
                        latch       <= 1'b0;
                        bus.ped_ack <= 1'b1;
`endif
                     end else if (bus.master_timer <= 7'd1) begin
                        bus.master_timer <= '0;
                        clear_count      <= '0;
                        state            <= (state == NS_GO) ? NS_CLEAR : EW_CLEAR;
`ifdef PED_REQUEST_EN
                        latch       <= 1'b0;
                        bus.ped_ack <= latch;
`endif
                     end else begin
                        bus.master_timer <= bus.master_timer - 7'd1;
                     end
                  end
               end

               NS_CLEAR, EW_CLEAR: begin
                  // Prescaler keeps free-running from the GO phase.
                  prescaler <= tick ? '0 : prescaler + PRE_ONE;
                  if (tick) begin
                     if (clear_count == CLEAR_LAST) begin
                        clear_count      <= '0;
                        prescaler        <= '0;
                        bus.master_timer <= PHASE_LOAD;
                        bus.enable_ns    <= (state == EW_CLEAR);
                        bus.enable_ew    <= (state == NS_CLEAR);
                        state            <= (state == NS_CLEAR) ? EW_GO : NS_GO;
                     end else begin
                        clear_count <= clear_count + 4'd1;
                     end
                  end
               end

               default: begin
                  state            <= STOP;
                  prescaler        <= '0;
                  clear_count      <= '0;
                  bus.enable_ns    <= 1'b0;
                  bus.enable_ew    <= 1'b0;
                  bus.master_timer <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_intersection_controller.sv
// tb_intersection_controller
//   Two instances with TICKS_PER_SECOND=2, ALL_RED_TIME=2: u_dut_a with
//   PHASE_TIME=20 (sequencing, run, reset scenarios) and u_dut_b with
//   PHASE_TIME=40 (pedestrian scenarios). A model based on elapsed cycles
//   since phase entry predicts every output each cycle; directed literal
//   checks pin key points of the sequence.
module tb_intersection_controller;

`ifdef PED_REQUEST_EN
   localparam bit PED_ON = 1'b1;
`else
   localparam bit PED_ON = 1'b0;
`endif
   localparam int T   = 2;
   localparam int A   = 2;
   localparam int P_A = 20;
   localparam int P_B = 40;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   intersection_controller_if bus_a ();
   intersection_controller_if bus_b ();

   intersection_controller #(
      .TICKS_PER_SECOND(2),
      .PHASE_TIME(P_A),
      .ALL_RED_TIME(A)
   ) u_dut_a (
      .clock(clock),
      .reset(reset),
      .bus(bus_a)
   );

   intersection_controller #(
      .TICKS_PER_SECOND(2),
      .PHASE_TIME(P_B),
      .ALL_RED_TIME(A)
   ) u_dut_b (
      .clock(clock),
      .reset(reset),
      .bus(bus_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: elapsed-time view of each instance -------------
   bit m_armed;
   bit m_go    [2];
   bit m_ns    [2];
   bit m_clr   [2];
   bit m_latch [2];
   bit m_ack   [2];
   int m_e     [2];   // cycles since current GO entry
   int m_base  [2];   // timer value at m_ebase
   int m_ebase [2];
   int m_cstart[2];   // m_e at which clearance began

   function automatic int model_timer(input int i);
      if (!m_go[i] || m_clr[i]) return 0;
      return m_base[i] - (m_e[i] - m_ebase[i]) / T;
   endfunction

   task automatic start_go(input int i, input bit ns, input int p);
      m_go[i]    = 1'b1;
      m_ns[i]    = ns;
      m_clr[i]   = 1'b0;
      m_e[i]     = 0;
      m_base[i]  = p;
      m_ebase[i] = 0;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_armed = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_go[i]    = 1'b0;
            m_latch[i] = 1'b0;
            m_ack[i]   = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit run_i;
            bit ped_i;
            bit latch_old;
            int p_i;
            int t_old;
            run_i = (i == 0) ? bus_a.run : bus_b.run;
            ped_i = (i == 0) ? bus_a.ped_request : bus_b.ped_request;
            p_i   = (i == 0) ? P_A : P_B;
            m_ack[i] = 1'b0;
            if (!run_i) begin
               m_go[i]    = 1'b0;
               m_latch[i] = 1'b0;
            end else if (!m_go[i]) begin
               if (m_armed) start_go(i, 1'b1, p_i);
            end else if (m_clr[i]) begin
               m_e[i]++;
               if (m_e[i] - m_cstart[i] == A * T) start_go(i, !m_ns[i], p_i);
            end else begin
               t_old     = model_timer(i);
               latch_old = m_latch[i];
               if (PED_ON && ped_i) m_latch[i] = 1'b1;
               m_e[i]++;
               if (m_e[i] % T == 0) begin
                  if (PED_ON && latch_old && t_old > 15) begin
                     m_base[i]  = 15;
                     m_ebase[i] = m_e[i];
                     m_latch[i] = 1'b0;
                     m_ack[i]   = 1'b1;
                  end else if (model_timer(i) == 0) begin
                     m_clr[i]    = 1'b1;
                     m_cstart[i] = m_e[i];
                     m_ack[i]    = latch_old;
                     m_latch[i]  = 1'b0;
                  end
               end
            end
         end
         m_armed = 1'b1;
      end
   end

   // ---------------- per-cycle compare ---------------------------------------
   task automatic cmp_dut(input int i, input logic ns, input logic ew,
                          input logic [6:0] t, input logic ack);
      chk($sformatf("enable_ns[%0d]", i), 32'(ns), 32'(m_go[i] && m_ns[i]));
      chk($sformatf("enable_ew[%0d]", i), 32'(ew), 32'(m_go[i] && !m_ns[i]));
      chk($sformatf("master_timer[%0d]", i), 32'(t), 32'(model_timer(i)));
      chk($sformatf("ped_ack[%0d]", i), 32'(ack), 32'(m_ack[i]));
      chk($sformatf("exclusive[%0d]", i), 32'(ns & ew), 32'd0);
   endtask

   always @(negedge clock) begin
      cmp_dut(0, bus_a.enable_ns, bus_a.enable_ew, bus_a.master_timer, bus_a.ped_ack);
      cmp_dut(1, bus_b.enable_ns, bus_b.enable_ew, bus_b.master_timer, bus_b.ped_ack);
   end

   // ---------------- directed stimulus with literal expectations -----------
   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic lit_a(input string name, input int ns, input int ew, input int t, input int ack);
      chk({name, ".ns"}, 32'(bus_a.enable_ns), 32'(ns));
      chk({name, ".ew"}, 32'(bus_a.enable_ew), 32'(ew));
      chk({name, ".timer"}, 32'(bus_a.master_timer), 32'(t));
      chk({name, ".ack"}, 32'(bus_a.ped_ack), 32'(ack));
   endtask

   task automatic lit_b(input string name, input int ns, input int ew, input int t, input int ack);
      chk({name, ".ns"}, 32'(bus_b.enable_ns), 32'(ns));
      chk({name, ".ew"}, 32'(bus_b.enable_ew), 32'(ew));
      chk({name, ".timer"}, 32'(bus_b.master_timer), 32'(t));
      chk({name, ".ack"}, 32'(bus_b.ped_ack), 32'(ack));
   endtask

   initial begin
      bus_a.run         = 1'b0;
      bus_a.ped_request = 1'b0;
      bus_b.run         = 1'b0;
      bus_b.ped_request = 1'b0;
      #1 reset = 1'b1;
      #2;
      lit_a("reset_a", 0, 0, 0, 0);
      lit_b("reset_b", 0, 0, 0, 0);

      // Sequencing on instance A.
      bus_a.run = 1'b1;
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;
      cyc(1);  lit_a("stop_hold", 0, 0, 0, 0);
      cyc(1);  lit_a("ns_entry", 1, 0, 20, 0);
      cyc(2);  lit_a("ns_first_dec", 1, 0, 19, 0);
      cyc(37); lit_a("ns_t1", 1, 0, 1, 0);
      cyc(1);  lit_a("ns_clear_start", 1, 0, 0, 0);
      cyc(3);  lit_a("ns_clear_end", 1, 0, 0, 0);
      cyc(1);  lit_a("ew_entry", 0, 1, 20, 0);
      cyc(44); lit_a("period_88", 1, 0, 20, 0);
      cyc(66); lit_a("ew_t9", 0, 1, 9, 0);

      // run=0 mid EW_GO, then restart.
      bus_a.run = 1'b0;
      cyc(1);  lit_a("run_off", 0, 0, 0, 0);
      cyc(2);  bus_a.run = 1'b1;
      cyc(1);  lit_a("run_restart", 1, 0, 20, 0);

      // Asynchronous reset during NS_CLEAR.
      cyc(41); lit_a("pre_reset_clear", 1, 0, 0, 0);
      #2 reset = 1'b1;
      #1 lit_a("async_reset", 0, 0, 0, 0);
      @(negedge clock);
      #2 reset = 1'b0;
      cyc(1);  lit_a("reset_stop_hold", 0, 0, 0, 0);
      cyc(1);  lit_a("reset_ns_entry", 1, 0, 20, 0);

      // Instance B: request at timer=30.
      bus_b.run = 1'b1;
      cyc(1);  lit_b("b_entry", 1, 0, 40, 0);
      cyc(20); lit_b("b_t30", 1, 0, 30, 0);
      bus_b.ped_request = 1'b1;
      cyc(1);  bus_b.ped_request = 1'b0;
      cyc(1);  lit_b("b_ped_cut", 1, 0, PED_ON ? 15 : 29, PED_ON ? 1 : 0);
      cyc(1);  lit_b("b_ack_one_cycle", 1, 0, PED_ON ? 15 : 29, 0);
      cyc(1);  lit_b("b_after_cut", 1, 0, PED_ON ? 14 : 28, 0);
      bus_b.run = 1'b0;
      cyc(1);  lit_b("b_stop1", 0, 0, 0, 0);

      // Instance B: request at timer=10, served at GO exit; CLEAR ignores it.
      bus_b.run = 1'b1;
      cyc(1);  lit_b("b2_entry", 1, 0, 40, 0);
      cyc(60); lit_b("b2_t10", 1, 0, 10, 0);
      bus_b.ped_request = 1'b1;
      cyc(1);  bus_b.ped_request = 1'b0;
      cyc(18); lit_b("b2_t1", 1, 0, 1, 0);
      cyc(1);  lit_b("b2_exit_ack", 1, 0, 0, PED_ON ? 1 : 0);
      cyc(1);  lit_b("b2_exit_ack_off", 1, 0, 0, 0);
      bus_b.ped_request = 1'b1;
      cyc(1);  bus_b.ped_request = 1'b0;
      cyc(2);  lit_b("b2_ew_entry", 0, 1, 40, 0);
      cyc(2);  lit_b("b2_ew_no_cut", 0, 1, 39, 0);
      bus_b.run = 1'b0;
      cyc(1);

      // Instance B: run=0 drops a pending request without ack.
      bus_b.run = 1'b1;
      cyc(1);  lit_b("b3_entry", 1, 0, 40, 0);
      cyc(10); lit_b("b3_t35", 1, 0, 35, 0);
      bus_b.ped_request = 1'b1;
      cyc(1);  bus_b.ped_request = 1'b0;
      bus_b.run = 1'b0;
      cyc(1);  lit_b("b3_stop_no_ack", 0, 0, 0, 0);
      bus_b.run = 1'b1;
      cyc(1);  lit_b("b3_restart", 1, 0, 40, 0);
      cyc(2);  lit_b("b3_latch_dropped", 1, 0, 39, 0);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
